// File: rtl/spi_slave_rx_mode2.sv
// rtl/spi_slave_rx_mode2.sv - SPI mode 2 (CPOL=1, CPHA=0) receive-only slave with valid/ready word output
// Optional: define SPI_RX_BYTE_CNT_EN to add Out_byte_cnt, the completed-word count of the current frame.
module spi_slave_rx_mode2 #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  In_clk,
   input  logic                  In_rst,
   input  logic                  In_spi_cs_n,
   input  logic                  In_spi_sclk,
   input  logic                  In_spi_mosi,
   output logic [DATA_WIDTH-1:0] Out_rx_data,
   output logic                  Out_rx_valid,
   input  logic                  In_rx_ready,
   output logic                  Out_busy,
   output logic                  Out_frame_err,
   output logic                  Out_overrun
`ifdef SPI_RX_BYTE_CNT_EN
   ,
   output logic [7:0]            Out_byte_cnt
`endif
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_cs_meta, r_cs_sync, r_cs_prev;
   logic                  r_sclk_meta, r_sclk_sync, r_sclk_prev;
   logic                  r_mosi_meta, r_mosi_sync;
   logic [CNT_W-1:0]      r_bit_cnt;
   logic [CNT_W-1:0]      w_cnt_next;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic [DATA_WIDTH-1:0] r_rx_data;
   logic                  r_rx_valid;
   logic                  r_frame_err;
   logic                  r_overrun;
   logic                  w_cs_fall, w_cs_rise, w_sclk_fall;
   logic                  w_frame_start, w_edge, w_word_done, w_trunc;

   // Synchronizers reset to the bus idle levels so reset release never fakes an edge.
   always_ff @(posedge In_clk) begin
      if (In_rst) begin
         r_cs_meta   <= 1'b1;
         r_cs_sync   <= 1'b1;
         r_cs_prev   <= 1'b1;
         r_sclk_meta <= 1'b1;
         r_sclk_sync <= 1'b1;
         r_sclk_prev <= 1'b1;
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
      end else begin
         r_cs_meta   <= In_spi_cs_n;
         r_cs_sync   <= r_cs_meta;
         r_cs_prev   <= r_cs_sync;
         r_sclk_meta <= In_spi_sclk;
         r_sclk_sync <= r_sclk_meta;
         r_sclk_prev <= r_sclk_sync;
         r_mosi_meta <= In_spi_mosi;
         r_mosi_sync <= r_mosi_meta;
      end
   end

   assign w_cs_fall     = r_cs_prev & ~r_cs_sync;
   assign w_cs_rise     = ~r_cs_prev & r_cs_sync;
   assign w_sclk_fall   = r_sclk_prev & ~r_sclk_sync;
   assign w_frame_start = (r_state == IDLE) & w_cs_fall;
   assign w_edge        = (r_state == RECV) & w_sclk_fall;
   assign w_word_done   = w_edge & (r_bit_cnt == LAST_BIT);
   assign w_shift_next  = {r_shift[DATA_WIDTH-2:0], r_mosi_sync};

   always_comb begin
      w_cnt_next = r_bit_cnt;
      if (w_word_done)
         w_cnt_next = '0;
      else if (w_edge)
         w_cnt_next = r_bit_cnt + CNT_W'(1);
   end

   // A final edge seen together with the cs_n rise is counted first, so a just-completed word is not truncated.
   assign w_trunc = (r_state == RECV) & w_cs_rise & (w_cnt_next != '0);

   always_ff @(posedge In_clk) begin
      if (In_rst)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_cs_fall) w_state_next = RECV;
         RECV:    if (w_cs_rise) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      Out_busy = (r_state == RECV);
   end

   always_ff @(posedge In_clk) begin
      if (In_rst) begin
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_trunc;
         r_overrun   <= w_word_done & r_rx_valid & ~In_rx_ready;
         if (w_frame_start)
            r_bit_cnt <= '0;
         else
            r_bit_cnt <= w_cnt_next;
         if (w_edge)
            r_shift <= w_shift_next;
         if (w_word_done) begin
            r_rx_data  <= w_shift_next;
            r_rx_valid <= 1'b1;
         end else if (r_rx_valid && In_rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign Out_rx_data   = r_rx_data;
   assign Out_rx_valid  = r_rx_valid;
   assign Out_frame_err = r_frame_err;
   assign Out_overrun   = r_overrun;

`ifdef SPI_RX_BYTE_CNT_EN
   logic [7:0] r_byte_cnt;

   always_ff @(posedge In_clk) begin
      if (In_rst)
         r_byte_cnt <= 8'd0;
      else if (w_frame_start)
         r_byte_cnt <= 8'd0;
      else if (w_word_done)
         r_byte_cnt <= r_byte_cnt + 8'd1;
   end

   assign Out_byte_cnt = r_byte_cnt;
`endif

endmodule

// File: tb/tb_spi_slave_rx_mode2.sv
// tb/tb_spi_slave_rx_mode2.sv - self-checking bench for spi_slave_rx_mode2
// Optional: define SPI_RX_BYTE_CNT_EN to also exercise Out_byte_cnt.
module tb_spi_slave_rx_mode2;

   typedef logic [7:0] byte_q_t[$];

   logic       In_clk = 1'b0;
   logic       In_rst = 1'b1;
   logic       In_spi_cs_n = 1'b1;
   logic       In_spi_sclk = 1'b1;
   logic       In_spi_mosi = 1'b0;
   logic       In_rx_ready = 1'b1;
   logic [7:0] Out_rx_data;
   logic       Out_rx_valid;
   logic       Out_busy;
   logic       Out_frame_err;
   logic       Out_overrun;
`ifdef SPI_RX_BYTE_CNT_EN
   logic [7:0] Out_byte_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int err_cnt = 0;
   int ovr_cnt = 0;
   int stable_viol = 0;
   logic [7:0] got_q[$];
   logic       prev_valid = 1'b0;
   logic       prev_hs = 1'b0;
   logic [7:0] prev_data = 8'd0;

   spi_slave_rx_mode2 #(.DATA_WIDTH(8)) dut (
      .In_clk(In_clk),
      .In_rst(In_rst),
      .In_spi_cs_n(In_spi_cs_n),
      .In_spi_sclk(In_spi_sclk),
      .In_spi_mosi(In_spi_mosi),
      .Out_rx_data(Out_rx_data),
      .Out_rx_valid(Out_rx_valid),
      .In_rx_ready(In_rx_ready),
      .Out_busy(Out_busy),
      .Out_frame_err(Out_frame_err),
      .Out_overrun(Out_overrun)
`ifdef SPI_RX_BYTE_CNT_EN
      ,
      .Out_byte_cnt(Out_byte_cnt)
`endif
   );

   always #10 In_clk = ~In_clk;

   // Observer: accepted words, error/overrun pulse cycles, data changes while a word is pending.
   always @(negedge In_clk) begin
      if (In_rst) begin
         prev_valid <= 1'b0;
         prev_hs    <= 1'b0;
      end else begin
         if (Out_rx_valid && In_rx_ready) got_q.push_back(Out_rx_data);
         if (Out_frame_err) err_cnt <= err_cnt + 1;
         if (Out_overrun) ovr_cnt <= ovr_cnt + 1;
         if (prev_valid && !prev_hs && Out_rx_valid && (Out_rx_data !== prev_data) && !Out_overrun)
            stable_viol <= stable_viol + 1;
         prev_valid <= Out_rx_valid;
         prev_hs    <= Out_rx_valid && In_rx_ready;
         prev_data  <= Out_rx_data;
      end
   end

   task automatic clks(input int n);
      repeat (n) @(negedge In_clk);
   endtask

   task automatic set_ready(input logic v);
      @(negedge In_clk);
      #2 In_rx_ready = v;
   endtask

   task automatic spi_bits(input logic [31:0] v, input int nb, input int half);
      for (int i = nb - 1; i >= 0; i--) begin
         In_spi_mosi = v[i];
         clks(half);
         In_spi_sclk = 1'b0;
         clks(half);
         In_spi_sclk = 1'b1;
      end
   endtask

   task automatic frame(input byte_q_t words, input int half);
      In_spi_cs_n = 1'b0;
      clks(half);
      foreach (words[i]) spi_bits({24'd0, words[i]}, 8, half);
      clks(half);
      In_spi_cs_n = 1'b1;
      clks(2 * half + 8);
   endtask

   task automatic test_reset;
      In_rst = 1'b1;
      In_spi_mosi = 1'($urandom);
      clks(3);
      n_cmp++; if (Out_rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", Out_rx_data); end
      n_cmp++; if (Out_rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", Out_rx_valid); end
      n_cmp++; if (Out_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", Out_busy); end
      n_cmp++; if (Out_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got %b want 0", Out_frame_err); end
      n_cmp++; if (Out_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr got %b want 0", Out_overrun); end
      In_rst = 1'b0;
      clks(4);
   endtask

   task automatic test_single_a5;
      int q0 = got_q.size();
      int e0 = err_cnt;
      In_spi_cs_n = 1'b0;
      clks(6);
      n_cmp++; if (Out_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_on got %b want 1", Out_busy); end
      clks(494);
      spi_bits(32'hA5, 8, 500);
      clks(500);
      n_cmp++; if (Out_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_end got %b want 1", Out_busy); end
      In_spi_cs_n = 1'b1;
      clks(10);
      n_cmp++; if (Out_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_off got %b want 0", Out_busy); end
      n_cmp++; if (got_q.size() - q0 !== 1) begin n_bad++; $display("FAIL single_count got %0d want 1", got_q.size() - q0); end
      else begin
         n_cmp++; if (got_q[q0] !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", got_q[q0]); end
      end
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL single_ferr got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_two_words;
      byte_q_t w = '{8'h3C, 8'hC3};
      int q0 = got_q.size();
      int e0 = err_cnt;
      frame(w, $urandom_range(4, 12));
      n_cmp++; if (got_q.size() - q0 !== 2) begin n_bad++; $display("FAIL two_count got %0d want 2", got_q.size() - q0); end
      else begin
         for (int i = 0; i < 2; i++) begin
            n_cmp++; if (got_q[q0 + i] !== w[i]) begin n_bad++; $display("FAIL two_data[%0d] got %h want %h", i, got_q[q0 + i], w[i]); end
         end
      end
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL two_ferr got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_overrun;
      byte_q_t w = '{8'h11, 8'h22};
      int q0, o0;
      set_ready(1'b0);
      q0 = got_q.size();
      o0 = ovr_cnt;
      frame(w, $urandom_range(4, 12));
      n_cmp++; if (ovr_cnt - o0 !== 1) begin n_bad++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - o0); end
      n_cmp++; if (Out_rx_data !== 8'h22) begin n_bad++; $display("FAIL ovr_data got %h want 22", Out_rx_data); end
      clks(20);
      n_cmp++; if (Out_rx_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid_hold got %b want 1", Out_rx_valid); end
      n_cmp++; if (got_q.size() !== q0) begin n_bad++; $display("FAIL ovr_no_accept got %0d want %0d", got_q.size(), q0); end
      set_ready(1'b1);
      clks(1);
      n_cmp++; if (Out_rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_valid_clear got %b want 0", Out_rx_valid); end
   endtask

   task automatic test_frame_err;
      byte_q_t w = '{8'h5A};
      int q0 = got_q.size();
      int e0 = err_cnt;
      In_spi_cs_n = 1'b0;
      clks(6);
      spi_bits(32'h1F, 5, 6);
      clks(6);
      In_spi_cs_n = 1'b1;
      clks(12);
      n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL ferr_pulse_cycles got %0d want 1", err_cnt - e0); end
      n_cmp++; if (Out_rx_valid !== 1'b0) begin n_bad++; $display("FAIL ferr_valid got %b want 0", Out_rx_valid); end
      n_cmp++; if (got_q.size() !== q0) begin n_bad++; $display("FAIL ferr_no_word got %0d want %0d", got_q.size(), q0); end
      frame(w, 7);
      n_cmp++; if (got_q.size() - q0 !== 1) begin n_bad++; $display("FAIL ferr_next_count got %0d want 1", got_q.size() - q0); end
      else begin
         n_cmp++; if (got_q[q0] !== 8'h5A) begin n_bad++; $display("FAIL ferr_next_data got %h want 5a", got_q[q0]); end
      end
   endtask

   task automatic test_reset_midword;
      byte_q_t w = '{8'h81};
      int q0, e0;
      e0 = err_cnt;
      In_spi_cs_n = 1'b0;
      clks(6);
      spi_bits($urandom, 4, 6);
      In_rst = 1'b1;
      clks(1);
      n_cmp++; if (Out_rx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data got %h want 00", Out_rx_data); end
      n_cmp++; if (Out_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", Out_busy); end
      n_cmp++; if (Out_rx_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", Out_rx_valid); end
      In_rst = 1'b0;
      clks(8);
      n_cmp++; if (Out_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_cs_low_start got %b want 1", Out_busy); end
      In_spi_cs_n = 1'b1;
      clks(8);
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL rstmid_ferr got %0d want 0", err_cnt - e0); end
      q0 = got_q.size();
      frame(w, 6);
      n_cmp++; if (got_q.size() - q0 !== 1) begin n_bad++; $display("FAIL rstmid_count got %0d want 1", got_q.size() - q0); end
      else begin
         n_cmp++; if (got_q[q0] !== 8'h81) begin n_bad++; $display("FAIL rstmid_data2 got %h want 81", got_q[q0]); end
      end
   endtask

   task automatic test_cs_same_edge;
      logic [7:0] w = 8'($urandom);
      int q0 = got_q.size();
      int e0 = err_cnt;
      In_spi_cs_n = 1'b0;
      clks(6);
      spi_bits({25'd0, w[7:1]}, 7, 6);
      In_spi_mosi = w[0];
      clks(6);
      In_spi_sclk = 1'b0;
      In_spi_cs_n = 1'b1;
      clks(6);
      In_spi_sclk = 1'b1;
      clks(10);
      n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL same_edge_ferr got %0d want 0", err_cnt - e0); end
      n_cmp++; if (got_q.size() - q0 !== 1) begin n_bad++; $display("FAIL same_edge_count got %0d want 1", got_q.size() - q0); end
      else begin
         n_cmp++; if (got_q[q0] !== w) begin n_bad++; $display("FAIL same_edge_data got %h want %h", got_q[q0], w); end
      end
   endtask

   task automatic test_idle_edges;
      int q0 = got_q.size();
      spi_bits($urandom, 8, 4);
      clks(6);
      n_cmp++; if (got_q.size() !== q0 || Out_rx_valid !== 1'b0) begin n_bad++; $display("FAIL idle_edges got words=%0d valid=%b want 0 0", got_q.size() - q0, Out_rx_valid); end
   endtask

   task automatic test_latency;
      logic [7:0] w = 8'($urandom);
      int k = 0;
      set_ready(1'b0);
      In_spi_cs_n = 1'b0;
      clks(5);
      spi_bits({25'd0, w[7:1]}, 7, 5);
      In_spi_mosi = w[0];
      clks(5);
      In_spi_sclk = 1'b0;
      while (k < 8 && Out_rx_valid !== 1'b1) begin
         clks(1);
         k++;
      end
      n_cmp++; if (k > 4) begin n_bad++; $display("FAIL latency got %0d cycles want <=4", k); end
      n_cmp++; if (Out_rx_data !== w) begin n_bad++; $display("FAIL latency_data got %h want %h", Out_rx_data, w); end
      clks(5);
      In_spi_sclk = 1'b1;
      clks(5);
      In_spi_cs_n = 1'b1;
      clks(10);
      set_ready(1'b1);
      clks(2);
   endtask

   task automatic test_back_to_back;
      for (int it = 0; it < 6; it++) begin
         byte_q_t exp_q;
         int n = $urandom_range(1, 4);
         int q0 = got_q.size();
         int e0 = err_cnt;
         int o0 = ovr_cnt;
         for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
         frame(exp_q, $urandom_range(4, 12));
         n_cmp++; if (got_q.size() - q0 !== n) begin n_bad++; $display("FAIL b2b[%0d]_count got %0d want %0d", it, got_q.size() - q0, n); end
         else begin
            for (int i = 0; i < n; i++) begin
               n_cmp++; if (got_q[q0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b[%0d]_data[%0d] got %h want %h", it, i, got_q[q0 + i], exp_q[i]); end
            end
         end
         n_cmp++; if (err_cnt - e0 !== 0 || ovr_cnt - o0 !== 0) begin n_bad++; $display("FAIL b2b[%0d]_pulses got ferr=%0d ovr=%0d want 0 0", it, err_cnt - e0, ovr_cnt - o0); end
      end
   endtask

`ifdef SPI_RX_BYTE_CNT_EN
   task automatic test_byte_cnt;
      byte_q_t w;
      for (int i = 0; i < 3; i++) w.push_back(8'($urandom));
      frame(w, 5);
      n_cmp++; if (Out_byte_cnt !== 8'd3) begin n_bad++; $display("FAIL byte_cnt_hold got %0d want 3", Out_byte_cnt); end
      In_spi_cs_n = 1'b0;
      clks(5);
      n_cmp++; if (Out_byte_cnt !== 8'd0) begin n_bad++; $display("FAIL byte_cnt_clear got %0d want 0", Out_byte_cnt); end
      In_spi_cs_n = 1'b1;
      clks(6);
   endtask
`endif

   initial begin
      test_reset;
      test_single_a5;
      test_two_words;
      test_overrun;
      test_frame_err;
      test_reset_midword;
      test_cs_same_edge;
      test_idle_edges;
      test_latency;
      test_back_to_back;
`ifdef SPI_RX_BYTE_CNT_EN
      test_byte_cnt;
`endif
      n_cmp++; if (stable_viol !== 0) begin n_bad++; $display("FAIL data_stable_while_valid got %0d changes want 0", stable_viol); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
